rr_prio_arbiter: RTL and testbench

- Registered N-way arbiter that shares one resource among N requesters.
- Priority search is highest-index-first, identical to the bin2prio convention, with an optional rotating (round-robin) pointer.
- The granted requester keeps the grant while its request stays high, subject to a programmable hold limit; a one-hot grant and its binary index are both output.
- Sits in front of shared datapath resources (bus ports, shared ALUs, memory banks) in the basic benchmark group.

---
 rtl/rr_prio_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_prio_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_prio_arbiter.sv
// Registered N-way arbiter: highest-index-first search with optional rotating pointer,
// grant retention while requested, and a hold limit that yields to other pending requesters.
module rr_prio_arbiter #(
    parameter int N       = 8,
    parameter int MAXHOLD = 4,
    parameter int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rr_en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id
);

    localparam int HW   = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam int HMAX = (MAXHOLD > 0) ? MAXHOLD - 1 : 0;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HMAX);
    localparam logic [IW-1:0] TOP_IDX   = IW'(N - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [IW-1:0] startIdx;
    logic [IW:0]   pickAll;
    logic [IW:0]   pickOther;
    logic          newGrant;
    logic [IW-1:0] winId;

    // Returns {found, index} for the first set bit scanning start, start-1, ... with wrap.
    // Scanning from the lowest priority upward lets the last hit be the winner.
    function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] start);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(start) - off;
            if (idx < 0) begin
                idx = idx + N;
            end
            if (r[IW'(idx)]) begin
                res = {1'b1, IW'(idx)};
            end
        end
        return res;
    endfunction

    assign startIdx  = rr_en ? ptr_q : TOP_IDX;
    assign pickAll   = pick(req, startIdx);
    assign pickOther = pick(req & ~grant_q, startIdx);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        newGrant = 1'b0;
        winId    = '0;

        case (state_q)
            IDLE: begin
                if (pickAll[IW]) begin
                    newGrant = 1'b1;
                    winId    = pickAll[IW-1:0];
                end
            end
            BUSY: begin
                if (!req[id_q]) begin
                    // Owner released: hand over in the same edge, or fall back to idle.
                    if (pickAll[IW]) begin
                        newGrant = 1'b1;
                        winId    = pickAll[IW-1:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        id_d    = '0;
                        hold_d  = '0;
                    end
                end else if ((MAXHOLD > 0) && (hold_q == HOLD_LAST) && pickOther[IW]) begin
                    newGrant = 1'b1;
                    winId    = pickOther[IW-1:0];
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (newGrant) begin
            state_d = BUSY;
            grant_d = {{(N-1){1'b0}}, 1'b1} << winId;
            valid_d = 1'b1;
            id_d    = winId;
            hold_d  = '0;
            ptr_d   = (winId == '0) ? TOP_IDX : winId - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= TOP_IDX;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Directed testbench for rr_prio_arbiter (N=8, MAXHOLD=4) with hand-computed expectations.
module tb_rr_prio_arbiter;

    logic       clk;
    logic       rst;
    logic       rr_en;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;

    int passCount;
    int checkCount;

    logic [7:0] expG;
    logic [2:0] expId;
    logic       expV;

    rr_prio_arbiter #(
        .N      (8),
        .MAXHOLD(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rr_en      (rr_en),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle away from it.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [7:0] reqVal, input logic rrVal);
        rst   = 1'b1;
        req   = reqVal;
        rr_en = rrVal;
        stepCycle();
        stepCycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset(8'h00, 1'b0);
        checkCount++;
        if ({grant, grant_valid, grant_id} !== 12'h000)
            $display("[TB] FAIL reset_state: got grant=%b valid=%b id=%0d, expected all zero",
                     grant, grant_valid, grant_id);
        else passCount++;
    endtask

    task automatic test_fixed_priority();
        doReset(8'b00110110, 1'b0);
        stepCycle();
        checkCount++;
        if ({grant, grant_valid, grant_id} !== {8'b00100000, 1'b1, 3'd5})
            $display("[TB] FAIL fixed_first: got grant=%b valid=%b id=%0d, expected 00100000/1/5",
                     grant, grant_valid, grant_id);
        else passCount++;
        req = 8'b00010110;
        stepCycle();
        checkCount++;
        if ({grant, grant_valid, grant_id} !== {8'b00010000, 1'b1, 3'd4})
            $display("[TB] FAIL fixed_handover: got grant=%b valid=%b id=%0d, expected 00010000/1/4",
                     grant, grant_valid, grant_id);
        else passCount++;
        // A higher requester arriving must wait for the owner's hold limit.
        req = 8'b10010110;
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            expId = (c < 3) ? 3'd4 : 3'd7;
            checkCount++;
            if (grant_id !== expId || grant_valid !== 1'b1)
                $display("[TB] FAIL no_early_preempt[%0d]: got id=%0d valid=%b, expected id=%0d valid=1",
                         c, grant_id, grant_valid, expId);
            else passCount++;
        end
    endtask

    task automatic test_hold_limit();
        doReset(8'b10000001, 1'b0);
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            expId = (((c / 4) % 2) == 0) ? 3'd7 : 3'd0;
            expG  = 8'h01 << expId;
            checkCount++;
            if ({grant, grant_valid, grant_id} !== {expG, 1'b1, expId})
                $display("[TB] FAIL hold_limit[%0d]: got grant=%b id=%0d, expected grant=%b id=%0d",
                         c, grant, grant_id, expG, expId);
            else passCount++;
        end
    endtask

    task automatic test_round_robin();
        doReset(8'hFF, 1'b1);
        for (int c = 0; c < 36; c++) begin
            stepCycle();
            expId = 3'(7 - ((c / 4) % 8));
            expG  = 8'h01 << expId;
            checkCount++;
            if ({grant, grant_valid, grant_id} !== {expG, 1'b1, expId})
                $display("[TB] FAIL round_robin[%0d]: got grant=%b id=%0d, expected grant=%b id=%0d",
                         c, grant, grant_id, expG, expId);
            else passCount++;
        end
    endtask

    task automatic test_sole_requester();
        doReset(8'b00001000, 1'b1);
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            checkCount++;
            if ({grant, grant_valid, grant_id} !== {8'b00001000, 1'b1, 3'd3})
                $display("[TB] FAIL sole_hold[%0d]: got grant=%b valid=%b id=%0d, expected 00001000/1/3",
                         c, grant, grant_valid, grant_id);
            else passCount++;
        end
        req = 8'h00;
        stepCycle();
        checkCount++;
        if ({grant, grant_valid, grant_id} !== 12'h000)
            $display("[TB] FAIL sole_release: got grant=%b valid=%b id=%0d, expected all zero",
                     grant, grant_valid, grant_id);
        else passCount++;
    endtask

    task automatic test_async_reset();
        doReset(8'b00001000, 1'b0);
        stepCycle();
        checkCount++;
        if (grant_id !== 3'd3 || grant_valid !== 1'b1)
            $display("[TB] FAIL async_pre: got id=%0d valid=%b, expected id=3 valid=1",
                     grant_id, grant_valid);
        else passCount++;
        #2;
        rst = 1'b1;
        #1;
        checkCount++;
        if ({grant, grant_valid, grant_id} !== 12'h000)
            $display("[TB] FAIL async_clear: got grant=%b valid=%b id=%0d, expected all zero before edge",
                     grant, grant_valid, grant_id);
        else passCount++;
        stepCycle();
        req = 8'h09;
        rst = 1'b0;
        stepCycle();
        checkCount++;
        if ({grant, grant_valid, grant_id} !== {8'b00001000, 1'b1, 3'd3})
            $display("[TB] FAIL async_restart: got grant=%b valid=%b id=%0d, expected 00001000/1/3",
                     grant, grant_valid, grant_id);
        else passCount++;
    endtask

    task automatic test_single_bit_sweep();
        doReset(8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            req  = 8'h01 << i;
            expG = 8'h01 << i;
            stepCycle();
            checkCount++;
            if ({grant, grant_valid, grant_id} !== {expG, 1'b1, 3'(i)})
                $display("[TB] FAIL sweep_grant[%0d]: got grant=%b valid=%b id=%0d, expected %b/1/%0d",
                         i, grant, grant_valid, grant_id, expG, i);
            else passCount++;
            req = 8'h00;
            stepCycle();
            checkCount++;
            if ({grant, grant_valid, grant_id} !== 12'h000)
                $display("[TB] FAIL sweep_idle[%0d]: got grant=%b valid=%b id=%0d, expected all zero",
                         i, grant, grant_valid, grant_id);
            else passCount++;
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst   = 1'b1;
        rr_en = 1'b0;
        req   = 8'h00;
        test_reset();
        test_fixed_priority();
        test_hold_limit();
        test_round_robin();
        test_sole_requester();
        test_async_reset();
        test_single_bit_sweep();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
